hazard_stall_unit: RTL and testbench

Stall/bubble controller that complements the forwarding unit in the 5-stage RV32 pipeline with the 4-cycle multiplier.
- Detects RAW hazards that forwarding cannot resolve. Load results are never forwarded from MEM, only from WB.
- Holds the front of the pipeline while a multi-cycle multiply occupies EX.
- Sits beside the ID stage and drives the write enables of PC, IF/ID and ID/EX, plus the ID/EX and EX/MEM bubble controls.

---
 rtl/hazard_stall_unit.sv | 145 ++++++++++++++
 tb/tb_hazard_stall_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: stall/bubble controller beside the ID stage of the
// 5-stage RV32 pipeline. Stalls the front end on load-use hazards that
// forwarding cannot cover and freezes the front end while a multi-cycle
// multiply occupies EX.
// Optional build macro HAZARD_STALL_COUNTERS_EN adds the free-running
// load_stall_cnt / mul_stall_cnt outputs.
module hazard_stall_unit #(
   parameter int unsigned MUL_CYCLES = 4
) (
   input  logic        clk,
   input  logic        arst,
   input  logic [4:0]  rs1_IF_ID,
   input  logic [4:0]  rs2_IF_ID,
   input  logic        use_rs1_ID,
   input  logic        use_rs2_ID,
   input  logic [4:0]  rd_ID_EX,
   input  logic        mem_2_reg_EX,
   input  logic        reg_write_EX,
   input  logic        mul_EX,
   input  logic [4:0]  rd_EX_MEM,
   input  logic        mem_2_reg_MEM,
   input  logic        reg_write_MEM,
   output logic        pc_write_en,
   output logic        if_id_write_en,
   output logic        id_ex_write_en,
   output logic        id_ex_flush,
   output logic        ex_mem_bubble,
`ifdef HAZARD_STALL_COUNTERS_EN
   output logic [31:0] load_stall_cnt,
   output logic [31:0] mul_stall_cnt,
`endif
   output logic        mul_busy
);

   // A one-cycle multiply never needs a hold; a two-cycle multiply is
   // handled entirely in IDLE with the one-shot done flag.
   localparam bit         MUL_HOLD_EN = (MUL_CYCLES > 1);
   localparam bit         MUL_LONG    = (MUL_CYCLES > 2);
   localparam logic [3:0] CNT_INIT    = MUL_HOLD_EN ? 4'(MUL_CYCLES - 2) : 4'd0;

   typedef enum logic {
      IDLE     = 1'b0,
      MUL_BUSY = 1'b1
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       done, done_nxt;
   logic       mh;
   logic       lh;
   logic       h_ex;
   logic       h_mem;

   // True when the ID instruction actually reads register r (x0 excluded).
   function automatic logic id_reads(input logic [4:0] r,
                                     input logic [4:0] rs1, input logic u1,
                                     input logic [4:0] rs2, input logic u2);
      return (r != 5'd0) && ((u1 && (rs1 == r)) || (u2 && (rs2 == r)));
   endfunction

   // Load-use detection: a load result is only available from WB, so a
   // consumer must wait while the load sits in either EX or MEM.
   always_comb begin
      h_ex  = mem_2_reg_EX  && reg_write_EX  &&
              id_reads(rd_ID_EX,  rs1_IF_ID, use_rs1_ID, rs2_IF_ID, use_rs2_ID);
      h_mem = mem_2_reg_MEM && reg_write_MEM &&
              id_reads(rd_EX_MEM, rs1_IF_ID, use_rs1_ID, rs2_IF_ID, use_rs2_ID);
      lh    = h_ex || h_mem;
   end

   // Multiply-hold FSM next state and pipeline control outputs.
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      done_nxt       = 1'b0;
      mh             = 1'b0;
      pc_write_en    = 1'b1;
      if_id_write_en = 1'b1;
      id_ex_write_en = 1'b1;
      id_ex_flush    = 1'b0;
      ex_mem_bubble  = 1'b0;
      mul_busy       = 1'b0;

      case (state)
         IDLE: begin
            // done blocks re-triggering on the same (still held) multiply
            mh = mul_EX && MUL_HOLD_EN && !done;
            if (mh) begin
               cnt_nxt = CNT_INIT;
               if (MUL_LONG) state_nxt = MUL_BUSY;
               else          done_nxt  = 1'b1;
            end
         end
         MUL_BUSY: begin
            if (cnt != 4'd0) begin
               mh      = 1'b1;
               cnt_nxt = cnt - 4'd1;
            end else begin
               // multiply leaves EX at this edge
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (mh) begin
         pc_write_en    = 1'b0;
         if_id_write_en = 1'b0;
         id_ex_write_en = 1'b0;
         ex_mem_bubble  = 1'b1;
         mul_busy       = 1'b1;
      end else if (lh) begin
         pc_write_en    = 1'b0;
         if_id_write_en = 1'b0;
         id_ex_flush    = 1'b1;
      end
   end

   // FSM state, hold counter and one-shot done flag.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state <= IDLE;
         cnt   <= 4'd0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         done  <= done_nxt;
      end
   end

`ifdef HAZARD_STALL_COUNTERS_EN
   // Per-cycle stall statistics; both wrap naturally at 32 bits.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         load_stall_cnt <= 32'd0;
         mul_stall_cnt  <= 32'd0;
      end else begin
         if (lh && !mh) load_stall_cnt <= load_stall_cnt + 32'd1;
         if (mh)        mul_stall_cnt  <= mul_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed bench for hazard_stall_unit (MUL_CYCLES=4).
// Build with HAZARD_STALL_COUNTERS_EN defined to also cover the counters.
module tb_hazard_stall_unit;

   logic        clk;
   logic        arst;
   logic [4:0]  rs1_IF_ID, rs2_IF_ID, rd_ID_EX, rd_EX_MEM;
   logic        use_rs1_ID, use_rs2_ID;
   logic        mem_2_reg_EX, reg_write_EX, mul_EX;
   logic        mem_2_reg_MEM, reg_write_MEM;
   logic        pc_write_en, if_id_write_en, id_ex_write_en;
   logic        id_ex_flush, ex_mem_bubble, mul_busy;
`ifdef HAZARD_STALL_COUNTERS_EN
   logic [31:0] load_stall_cnt, mul_stall_cnt;
`endif

   // {pc_write_en, if_id_write_en, id_ex_write_en, id_ex_flush, ex_mem_bubble, mul_busy}
   localparam logic [5:0] NORMAL = 6'b111000;
   localparam logic [5:0] LSTALL = 6'b001100;
   localparam logic [5:0] MHOLD  = 6'b000011;

   typedef struct {
      string      tag;
      logic [5:0] exp;
   } sb_entry_t;

   sb_entry_t sb[$];
   int checks = 0;
   int errors = 0;

   hazard_stall_unit #(.MUL_CYCLES(4)) dut (
      .clk            (clk),
      .arst           (arst),
      .rs1_IF_ID      (rs1_IF_ID),
      .rs2_IF_ID      (rs2_IF_ID),
      .use_rs1_ID     (use_rs1_ID),
      .use_rs2_ID     (use_rs2_ID),
      .rd_ID_EX       (rd_ID_EX),
      .mem_2_reg_EX   (mem_2_reg_EX),
      .reg_write_EX   (reg_write_EX),
      .mul_EX         (mul_EX),
      .rd_EX_MEM      (rd_EX_MEM),
      .mem_2_reg_MEM  (mem_2_reg_MEM),
      .reg_write_MEM  (reg_write_MEM),
      .pc_write_en    (pc_write_en),
      .if_id_write_en (if_id_write_en),
      .id_ex_write_en (id_ex_write_en),
      .id_ex_flush    (id_ex_flush),
      .ex_mem_bubble  (ex_mem_bubble),
`ifdef HAZARD_STALL_COUNTERS_EN
      .load_stall_cnt (load_stall_cnt),
      .mul_stall_cnt  (mul_stall_cnt),
`endif
      .mul_busy       (mul_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      rs1_IF_ID = 5'd0; rs2_IF_ID = 5'd0; use_rs1_ID = 1'b0; use_rs2_ID = 1'b0;
      rd_ID_EX = 5'd0; mem_2_reg_EX = 1'b0; reg_write_EX = 1'b0; mul_EX = 1'b0;
      rd_EX_MEM = 5'd0; mem_2_reg_MEM = 1'b0; reg_write_MEM = 1'b0;
   endtask

   // Push the expectation for the current inputs, compare at the falling
   // edge, then advance to just after the next rising edge.
   task automatic cycle(input string tag, input logic [5:0] exp);
      sb_entry_t e;
      logic [5:0] obs;
      sb.push_back('{tag: tag, exp: exp});
      @(negedge clk);
      obs = {pc_write_en, if_id_write_en, id_ex_write_en,
             id_ex_flush, ex_mem_bubble, mul_busy};
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard empty observed=%b", tag, obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
         end
      end
      @(posedge clk);
      #1;
   endtask

`ifdef HAZARD_STALL_COUNTERS_EN
   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
`endif

   initial begin
      arst = 1'b1;
      clear_inputs();

      // reset, quiet inputs
      cycle("reset", NORMAL);
`ifdef HAZARD_STALL_COUNTERS_EN
      chk32("rst_lcnt", load_stall_cnt, 32'd0);
      chk32("rst_mcnt", mul_stall_cnt, 32'd0);
`endif
      arst = 1'b0;

      // load x5 in EX, consumer reads rs1=x5
      rd_ID_EX = 5'd5; mem_2_reg_EX = 1'b1; reg_write_EX = 1'b1;
      rs1_IF_ID = 5'd5; use_rs1_ID = 1'b1;
      cycle("lu_hex", LSTALL);
      rd_ID_EX = 5'd0; mem_2_reg_EX = 1'b0; reg_write_EX = 1'b0;
      rd_EX_MEM = 5'd5; mem_2_reg_MEM = 1'b1; reg_write_MEM = 1'b1;
      cycle("lu_hmem", LSTALL);
      clear_inputs();
      rs1_IF_ID = 5'd5; use_rs1_ID = 1'b1;
      cycle("lu_done", NORMAL);

      // one plain multiply: 3 hold cycles then release
      clear_inputs();
      mul_EX = 1'b1;
      cycle("mul_a0", MHOLD);
      cycle("mul_a1", MHOLD);
      cycle("mul_a2", MHOLD);
      cycle("mul_a3", NORMAL);
`ifdef HAZARD_STALL_COUNTERS_EN
      chk32("lcnt_after", load_stall_cnt, 32'd2);
      chk32("mcnt_after", mul_stall_cnt, 32'd3);
`endif
      mul_EX = 1'b0;
      cycle("mul_idle", NORMAL);

      // x0 destination never stalls
      rd_ID_EX = 5'd0; mem_2_reg_EX = 1'b1; reg_write_EX = 1'b1;
      rs1_IF_ID = 5'd0; use_rs1_ID = 1'b1;
      cycle("x0_load", NORMAL);
      // rs2 matches but is not read
      clear_inputs();
      rd_ID_EX = 5'd5; mem_2_reg_EX = 1'b1; reg_write_EX = 1'b1;
      rs2_IF_ID = 5'd5; use_rs2_ID = 1'b0;
      cycle("rs2_unused", NORMAL);
      use_rs2_ID = 1'b1;
      cycle("rs2_used", LSTALL);
      // non-load producer in EX is forwarded, no stall
      mem_2_reg_EX = 1'b0;
      cycle("alu_fwd", NORMAL);
      // load that does not write rd
      mem_2_reg_EX = 1'b1; reg_write_EX = 1'b0;
      cycle("no_regwr", NORMAL);

      // multiply with a pending load-use: hold wins, flush after release
      clear_inputs();
      mul_EX = 1'b1;
      rd_EX_MEM = 5'd7; mem_2_reg_MEM = 1'b1; reg_write_MEM = 1'b1;
      rs1_IF_ID = 5'd7; use_rs1_ID = 1'b1;
      cycle("mp0", MHOLD);
      cycle("mp1", MHOLD);
      cycle("mp2", MHOLD);
      cycle("mp3", LSTALL);
      // back-to-back multiply gets a full hold
      clear_inputs();
      mul_EX = 1'b1;
      cycle("bb0", MHOLD);
      cycle("bb1", MHOLD);
      cycle("bb2", MHOLD);
      cycle("bb3", NORMAL);
      mul_EX = 1'b0;
      cycle("bb_idle", NORMAL);

      // async reset in the middle of a hold
      mul_EX = 1'b1;
      cycle("r0", MHOLD);
      cycle("r1", MHOLD);
      mul_EX = 1'b0;
      #2 arst = 1'b1;
      cycle("rst_mid", NORMAL);
`ifdef HAZARD_STALL_COUNTERS_EN
      chk32("rst_mid_mcnt", mul_stall_cnt, 32'd0);
`endif
      arst = 1'b0;
      mul_EX = 1'b1;
      cycle("n0", MHOLD);
      cycle("n1", MHOLD);
      cycle("n2", MHOLD);
      cycle("n3", NORMAL);
      mul_EX = 1'b0;
      cycle("n_idle", NORMAL);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
